// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring integer divider retiring one quotient bit per clock.
// Per-operation signed/unsigned selection; valid/ready handshake on operand and result sides.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int               CNT_W     = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               dvz;
    logic [CNT_W-1:0]   step;
    logic               neg_q;
    logic               neg_r;
    logic               ovf_pend;

    logic [WIDTH:0]     part_rem;
    logic [WIDTH-1:0]   quot_sh;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH+1:0]   trial;
    logic [WIDTH+1:0]   diff;
    logic               trial_neg;

    // MIN maps to 2^(WIDTH-1), which is still exact as an unsigned magnitude
    function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
        logic signed [WIDTH-1:0] m;
        m = (v < 0) ? -v : v;
        return m;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign in_ready = (state == IDLE);
    assign dvz      = (divisor == '0);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = dvz ? DONE : CALC;
                    end
                end
                CALC:    if (step == LAST_STEP) state_nxt = FIX;
                FIX:     state_nxt = DONE;
                DONE:    if (out_valid && out_ready) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            step        <= '0;
            out_valid   <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            ovf_pend    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt == DONE);
            if (accept) begin
                step        <= '0;
                neg_q       <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r       <= is_signed & dividend[WIDTH-1];
                ovf_pend    <= is_signed & (dividend == MIN_VAL) & (divisor == '1);
                div_by_zero <= dvz;
                overflow    <= 1'b0;
                if (dvz) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else if (state == CALC) begin
                step <= step + CNT_W'(1);
            end
            // abort in FIX must leave the previous result untouched
            if (!abort && state == FIX) begin
                quotient  <= apply_sign(quot_sh, neg_q);
                remainder <= apply_sign(part_rem[WIDTH-1:0], neg_r);
                overflow  <= ovf_pend;
            end
        end
    end

    // Trial subtraction carries one extra bit so its MSB is the borrow/sign
    assign trial     = {part_rem, quot_sh[WIDTH-1]};
    assign diff      = trial - {2'b00, dvs_mag};
    assign trial_neg = diff[WIDTH+1];

    always_ff @(posedge clk) begin
        if (accept) begin
            part_rem <= '0;
            quot_sh  <= is_signed ? magnitude(dividend) : dividend;
            dvs_mag  <= is_signed ? magnitude(divisor) : divisor;
        end else if (state == CALC) begin
            part_rem <= trial_neg ? trial[WIDTH:0] : diff[WIDTH:0];
            quot_sh  <= {quot_sh[WIDTH-2:0], ~trial_neg};
        end
    end

endmodule
